// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts spikes over WINDOW enabled cycles and hands each
// count downstream on valid/ready; also tracks the latest inter-spike interval.
module spike_rate_decoder #(
   parameter int WINDOW = 16,
   parameter int CNT_W  = 5,
   parameter int ISI_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             spike_in,
   output logic             rate_valid,
   input  logic             rate_ready,
   output logic [CNT_W-1:0] rate_count,
   output logic [ISI_W-1:0] last_isi,
   output logic             isi_valid,
   output logic             overrun
);

   localparam int WC_W = $clog2(WINDOW);
   localparam logic [WC_W-1:0] W_LAST = WC_W'(WINDOW - 1);

   logic [WC_W-1:0]  wcnt;
   logic [CNT_W-1:0] acc;
   logic [ISI_W-1:0] icnt;
   logic             seen;

   function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] a,
                                                input logic inc);
      if (&a) return a;
      return a + CNT_W'(inc);
   endfunction

   function automatic logic [ISI_W-1:0] sat_isi(input logic [ISI_W-1:0] a);
      if (&a) return a;
      return a + ISI_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         wcnt       <= '0;
         acc        <= '0;
         icnt       <= '0;
         seen       <= 1'b0;
         rate_valid <= 1'b0;
         rate_count <= '0;
         last_isi   <= '0;
         isi_valid  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         // An accept and a close on the same edge: the close assignment below wins.
         if (rate_valid && rate_ready)
            rate_valid <= 1'b0;

         if (en) begin
            if (wcnt == W_LAST) begin
               wcnt       <= '0;
               acc        <= '0;
               rate_count <= sat_cnt(acc, spike_in);
               rate_valid <= 1'b1;
               if (rate_valid && !rate_ready)
                  overrun <= 1'b1;
            end else begin
               wcnt <= wcnt + WC_W'(1);
               acc  <= sat_cnt(acc, spike_in);
            end

            if (spike_in) begin
               if (seen) begin
                  last_isi  <= sat_isi(icnt);
                  isi_valid <= 1'b1;
               end
               icnt <= '0;
               seen <= 1'b1;
            end else begin
               icnt <= sat_isi(icnt);
            end
         end
      end
   end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder (WINDOW=16, CNT_W=3, ISI_W=8).
module tb_spike_rate_decoder;

   localparam int WINDOW = 16;
   localparam int CNT_W  = 3;
   localparam int ISI_W  = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             spike_in;
   logic             rate_ready;
   logic             rate_valid;
   logic [CNT_W-1:0] rate_count;
   logic [ISI_W-1:0] last_isi;
   logic             isi_valid;
   logic             overrun;

   int vectors     = 0;
   int miscompares = 0;

   spike_rate_decoder #(.WINDOW(WINDOW), .CNT_W(CNT_W), .ISI_W(ISI_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .spike_in  (spike_in),
      .rate_valid(rate_valid),
      .rate_ready(rate_ready),
      .rate_count(rate_count),
      .last_isi  (last_isi),
      .isi_valid (isi_valid),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   // Inputs change 1ns after an edge; outputs are sampled at the same point.
   task automatic tick(input logic e, input logic s, input logic r);
      en         = e;
      spike_in   = s;
      rate_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0;
      // Reset held for two edges with spikes present
      tick(1, 1, 0);
      tick(1, 1, 0);
      chk("rst_valid",    32'(rate_valid), 0);
      chk("rst_count",    32'(rate_count), 0);
      chk("rst_isi",      32'(last_isi),   0);
      chk("rst_isivalid", 32'(isi_valid),  0);
      chk("rst_overrun",  32'(overrun),    0);
      rst = 1'b1;

      // Basic rate: spikes on window cycles 3,7,11,15
      for (int i = 0; i < 16; i++) begin
         tick(1, (i % 4) == 3, 1);
         if (i == 3)  chk("basic_isivalid_first", 32'(isi_valid), 0);
         if (i == 7) begin
            chk("basic_isivalid_second", 32'(isi_valid), 1);
            chk("basic_isi_second",      32'(last_isi),  4);
         end
         if (i == 14) chk("basic_valid_early", 32'(rate_valid), 0);
      end
      chk("basic_valid", 32'(rate_valid), 1);
      chk("basic_count", 32'(rate_count), 4);
      chk("basic_isi",   32'(last_isi),   4);
      chk("basic_ovr",   32'(overrun),    0);

      // Saturation: all 16 cycles spiking; first edge also consumes the result
      tick(1, 1, 1);
      chk("basic_valid_one_cycle", 32'(rate_valid), 0);
      for (int i = 1; i < 16; i++) tick(1, 1, 1);
      chk("sat_valid", 32'(rate_valid), 1);
      chk("sat_count", 32'(rate_count), 7);
      chk("sat_isi",   32'(last_isi),   1);

      // Back-pressure: window of 3 spikes, then 5, never accepted
      for (int i = 0; i < 16; i++) begin
         tick(1, (i == 0) || (i == 5) || (i == 10), i == 0);
         if (i == 0) chk("bp_accept_sat", 32'(rate_valid), 0);
      end
      chk("bp1_valid", 32'(rate_valid), 1);
      chk("bp1_count", 32'(rate_count), 3);
      chk("bp1_ovr",   32'(overrun),    0);
      for (int i = 0; i < 16; i++) begin
         tick(1, (i == 1) || (i == 3) || (i == 5) || (i == 7) || (i == 9), 0);
         if (i == 8) begin
            chk("bp_hold_valid", 32'(rate_valid), 1);
            chk("bp_hold_count", 32'(rate_count), 3);
         end
      end
      chk("bp2_valid", 32'(rate_valid), 1);
      chk("bp2_count", 32'(rate_count), 5);
      chk("bp2_ovr",   32'(overrun),    1);
      chk("bp2_isi",   32'(last_isi),   2);
      tick(0, 0, 1);
      chk("bp_accept_valid", 32'(rate_valid), 0);
      chk("bp_accept_ovr",   32'(overrun),    1);

      // Enable freeze: 10 gated cycles after window cycle 4
      for (int i = 0; i < 5; i++) tick(1, (i == 1) || (i == 4), 1);
      for (int i = 0; i < 10; i++) tick(0, (i % 2) == 0, 1);
      chk("frz_isi_held", 32'(last_isi),   3);
      chk("frz_no_close", 32'(rate_valid), 0);
      for (int i = 5; i < 16; i++) begin
         tick(1, i == 10, 1);
         if (i == 14) chk("frz_valid_early", 32'(rate_valid), 0);
      end
      chk("frz_valid", 32'(rate_valid), 1);
      chk("frz_count", 32'(rate_count), 3);
      chk("frz_isi",   32'(last_isi),   6);

      // Reset mid-window at wcnt=9 after 5 spikes
      for (int i = 0; i < 9; i++) tick(1, i < 5, 1);
      chk("mid_ovr_before", 32'(overrun), 1);
      rst = 1'b0;
      tick(1, 1, 1);
      rst = 1'b1;
      chk("mid_valid",    32'(rate_valid), 0);
      chk("mid_count",    32'(rate_count), 0);
      chk("mid_ovr",      32'(overrun),    0);
      chk("mid_isivalid", 32'(isi_valid),  0);
      chk("mid_isi",      32'(last_isi),   0);
      for (int i = 0; i < 16; i++) begin
         tick(1, (i == 2) || (i == 6), 0);
         if (i == 2) chk("post_isivalid_first", 32'(isi_valid), 0);
         if (i == 6) begin
            chk("post_isivalid", 32'(isi_valid), 1);
            chk("post_isi",      32'(last_isi),  4);
         end
         if (i == 14) chk("post_valid_early", 32'(rate_valid), 0);
      end
      chk("post_valid", 32'(rate_valid), 1);
      chk("post_count", 32'(rate_count), 2);

      // ISI saturation after a long silent stretch
      for (int i = 0; i < 300; i++) tick(1, 0, 1);
      tick(1, 1, 1);
      chk("isi_sat", 32'(last_isi), 255);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
